// File: rtl/eq_pkg.sv
// Shared mode encodings and run-tracker state type for the eq_tracker slice.
package eq_pkg;

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_NE = 2'b01,
        MODE_LT = 2'b10,
        MODE_GT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HIT  = 2'b10
    } run_state_e;

endpackage

// File: rtl/eq_cmp.sv
// Stateless operand comparator: equality, inequality and unsigned magnitude compares.
module eq_cmp
    import eq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             hit_c
);

    logic eq_c;

    assign eq_c = &(a ~^ b);

    always_comb begin
        hit_c = 1'b0;
        case (mode_e'(mode))
            MODE_EQ: hit_c = eq_c;
            MODE_NE: hit_c = ~eq_c;
            MODE_LT: hit_c = (a < b);
            MODE_GT: hit_c = (a > b);
            default: hit_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/eq_tracker.sv
// Registers per-sample compare results, counts matches with saturation and
// flags runs of RUN_LEN consecutive true results.
module eq_tracker
    import eq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    output logic             result,
    output logic [CNT_W-1:0] match_count,
    output logic             run_hit,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             hit_c;
    logic             out_valid_q, out_valid_d;
    logic             result_q, result_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             sat_q, sat_d;
    logic             run_hit_q, run_hit_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    run_state_e       state_q, state_d;

    eq_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a     (a),
        .b     (b),
        .mode  (mode),
        .hit_c (hit_c)
    );

    // Next-state: clear wins over counting, but the sample is still compared and output.
    always_comb begin
        out_valid_d   = in_valid;
        result_d      = result_q;
        match_count_d = match_count_q;
        sat_d         = sat_q;
        run_cnt_d     = run_cnt_q;
        state_d       = state_q;

        if (in_valid) begin
            result_d = hit_c;
        end

        if (clear) begin
            match_count_d = '0;
            sat_d         = 1'b0;
            run_cnt_d     = '0;
            state_d       = ST_IDLE;
        end else if (in_valid) begin
            if (hit_c && (match_count_q != CNT_MAX)) begin
                match_count_d = match_count_q + CNT_ONE;
            end
            sat_d = sat_q | (match_count_d == CNT_MAX);

            case (state_q)
                ST_IDLE: begin
                    if (hit_c) begin
                        run_cnt_d = CNT_ONE;
                        state_d   = (RUN_LEN_C == CNT_ONE) ? ST_HIT : ST_RUN;
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    if (hit_c) begin
                        run_cnt_d = run_cnt_q + CNT_ONE;
                        if ((run_cnt_q + CNT_ONE) == RUN_LEN_C) begin
                            state_d = ST_HIT;
                        end
                    end else begin
                        run_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
                ST_HIT: begin
                    if (!hit_c) begin
                        run_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    run_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            endcase
        end

        run_hit_d = (state_d == ST_HIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            result_q      <= 1'b0;
            match_count_q <= '0;
            sat_q         <= 1'b0;
            run_hit_q     <= 1'b0;
            run_cnt_q     <= '0;
            state_q       <= ST_IDLE;
        end else begin
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            match_count_q <= match_count_d;
            sat_q         <= sat_d;
            run_hit_q     <= run_hit_d;
            run_cnt_q     <= run_cnt_d;
            state_q       <= state_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign match_count = match_count_q;
    assign run_hit     = run_hit_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_eq_tracker.sv
// Self-checking bench for eq_tracker: vector table, directed corner sequences and
// a randomized phase, all scored against an independent behavioural model.
module tb_eq_tracker;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned RUN_LEN = 4;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       mode = 2'b00;
    logic             clear = 1'b0;
    logic             out_valid;
    logic             result;
    logic [CNT_W-1:0] match_count;
    logic             run_hit;
    logic             sat;

    eq_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .mode        (mode),
        .clear       (clear),
        .out_valid   (out_valid),
        .result      (result),
        .match_count (match_count),
        .run_hit     (run_hit),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ov;
        logic res;
        int   cnt;
        logic hit;
        logic st;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        int         a;
        int         b;
        logic       exp_res;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state
    logic m_ov, m_res, m_sat;
    int   m_cnt, m_st, m_run;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_cmp(input logic [1:0] md, input int av, input int bv);
        case (md)
            2'b00:   return av == bv;
            2'b01:   return av != bv;
            2'b10:   return av < bv;
            default: return av > bv;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic clr, input logic iv,
                              input logic [1:0] md, input int av, input int bv);
        logic h;
        exp_t e;
        h = model_cmp(md, av, bv);
        if (rst) begin
            m_ov = 0; m_res = 0; m_cnt = 0; m_sat = 0; m_st = 0; m_run = 0;
        end else begin
            m_ov = iv;
            if (iv) m_res = h;
            if (clr) begin
                m_cnt = 0; m_sat = 0; m_st = 0; m_run = 0;
            end else if (iv) begin
                if (h && m_cnt < CMAX) m_cnt++;
                if (m_cnt == CMAX) m_sat = 1;
                if (h) begin
                    if (m_st == 0) begin
                        m_run = 1;
                        m_st  = (RUN_LEN == 1) ? 2 : 1;
                    end else if (m_st == 1) begin
                        m_run++;
                        if (m_run == RUN_LEN) m_st = 2;
                    end
                end else begin
                    m_st = 0; m_run = 0;
                end
            end
        end
        e.ov = m_ov; e.res = m_res; e.cnt = m_cnt; e.hit = (m_st == 2); e.st = m_sat;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, advance past the edge, then score the DUT.
    task automatic step(input logic rst, input logic clr, input logic iv,
                        input logic [1:0] md, input int av, input int bv);
        exp_t e;
        reset = rst; clear = clr; in_valid = iv; mode = md;
        a = WIDTH'(av); b = WIDTH'(bv);
        model_step(rst, clr, iv, md, av, bv);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("out_valid", int'(out_valid), int'(e.ov));
            chk("result", int'(result), int'(e.res));
            chk("match_count", int'(match_count), e.cnt);
            chk("run_hit", int'(run_hit), int'(e.hit));
            chk("sat", int'(sat), int'(e.st));
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    endtask

    vec_t vecs[12];

    initial begin
        m_ov = 0; m_res = 0; m_sat = 0; m_cnt = 0; m_st = 0; m_run = 0;

        vecs[0]  = '{2'b00, 8'hA5, 8'hA5, 1'b1};
        vecs[1]  = '{2'b00, 8'hA5, 8'hA4, 1'b0};
        vecs[2]  = '{2'b10, 3,     200,   1'b1};
        vecs[3]  = '{2'b11, 255,   0,     1'b1};
        vecs[4]  = '{2'b01, 7,     7,     1'b0};
        vecs[5]  = '{2'b10, 200,   3,     1'b0};
        vecs[6]  = '{2'b11, 0,     255,   1'b0};
        vecs[7]  = '{2'b01, 1,     0,     1'b1};
        vecs[8]  = '{2'b00, 0,     0,     1'b1};
        vecs[9]  = '{2'b10, 5,     5,     1'b0};
        vecs[10] = '{2'b11, 5,     5,     1'b0};
        vecs[11] = '{2'b00, 8'h80, 8'h00, 1'b0};

        // Reset state
        step(1'b1, 1'b0, 1'b1, 2'b00, 1, 1);
        step(1'b1, 1'b0, 1'b0, 2'b00, 0, 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_match_count", int'(match_count), 0);

        // Table of single-sample compares
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, vecs[i].mode, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_result", i), int'(result), int'(vecs[i].exp_res));
            if (i == 0) chk("first_match_count", int'(match_count), 1);
            if (i == 1) chk("miss_match_count", int'(match_count), 1);
        end

        // Idle cycle: out_valid drops, result holds
        idle_step();
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_result_hold", int'(result), int'(vecs[11].exp_res));

        // Run across an idle gap
        step(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 9, 9);
        step(1'b0, 1'b0, 1'b1, 2'b10, 1, 9);
        idle_step();
        step(1'b0, 1'b0, 1'b1, 2'b11, 9, 1);
        chk("run_third_true", int'(run_hit), 0);
        step(1'b0, 1'b0, 1'b1, 2'b01, 9, 1);
        chk("run_fourth_true", int'(run_hit), 1);
        step(1'b0, 1'b0, 1'b1, 2'b00, 9, 1);
        chk("run_broken", int'(run_hit), 0);

        // Saturation then clear
        step(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b0, 1'b1, 2'b00, i, i);
            if (i == 14) chk("sat_before_max", int'(sat), 0);
            if (i == 15) chk("sat_at_max", int'(sat), 1);
        end
        chk("sat_count_held", int'(match_count), CMAX);
        step(1'b0, 1'b1, 1'b0, 2'b00, 0, 0);
        chk("clear_count", int'(match_count), 0);
        chk("clear_sat", int'(sat), 0);

        // Clear together with a true sample
        step(1'b0, 1'b0, 1'b1, 2'b00, 4, 4);
        step(1'b0, 1'b1, 1'b1, 2'b00, 4, 4);
        chk("clear_true_result", int'(result), 1);
        chk("clear_true_count", int'(match_count), 0);

        // Reset while in HIT with match_count=9
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 2'b00, 3, 3);
        chk("pre_reset_hit", int'(run_hit), 1);
        chk("pre_reset_count", int'(match_count), 9);
        step(1'b1, 1'b1, 1'b1, 2'b00, 3, 3);
        chk("post_reset_hit", int'(run_hit), 0);
        chk("post_reset_count", int'(match_count), 0);
        step(1'b0, 1'b0, 1'b1, 2'b00, 3, 3);
        chk("restart_from_idle", int'(run_hit), 0);

        // Randomized traffic with occasional clear/reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
